dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- FIFO store buffer between the CPU datapath and the data memory (dm).
- Accepts word stores from the datapath and drains them into dm, one per cycle, whenever dm's single address port is not needed by a load.
- Load lookups check the buffer first: a load that matches a pending store returns the youngest matching store data; otherwise it returns dm read data.

Parameters:
- DEPTH, 4, number of store entries; must be a power of 2, at least 2.
- PW, 2, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- st_req  input  1  datapath requests a word store this cycle.
- st_addr  input  32  store byte address; bits [1:0] ignored.
- st_wd  input  32  store data.
- st_pc  input  32  PC of the store instruction, carried to dm for its write log.
- st_ready  output  1  buffer can accept a store; equals not-full.
- ld_req  input  1  datapath performs a load this cycle.
- ld_addr  input  32  load byte address; bits [1:0] ignored.
- ld_data  output  32  load result: forwarded data or dm_D.
- ld_hit  output  1  ld_data comes from the buffer.
- dm_wr  output  1  write enable to dm (DMWr).
- dm_a  output  32  address to dm (A).
- dm_wd  output  32  write data to dm (WD).
- dm_pc  output  32  PC to dm.
- dm_d  input  32  dm combinational read data (D).
- empty  output  1  no pending stores; datapath uses this to order halt/syscall.

Behaviour:
- State:
  - DEPTH entries, each holding {valid, addr[31:2], wd, pc}.
  - head and tail pointers, PW bits each, wrapping modulo DEPTH.
  - count, PW+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- Reset:
  - Synchronous: head, tail and count go to 0 and all valid bits clear.
  - Pending stores are discarded, including when Reset arrives mid-drain; dm clears itself in the same cycle.
  - After reset: empty=1, st_ready=1, dm_wr=0, dm_a=0, dm_wd=0, dm_pc=0, ld_hit=0.
- Push:
  - Occurs when st_req && st_ready.
  - At posedge, the entry at tail is written with {1, st_addr[31:2], st_wd, st_pc} and tail increments.
  - st_req while full is ignored; nothing is written and no error is raised. The datapath must stall on !st_ready.
- Drain arbitration (combinational):
  - drain = !empty && !ld_req. Loads have priority on the dm port.
  - dm_wr = drain.
  - dm_a = ld_req ? {ld_addr[31:2],2'b00} : (empty ? 0 : {head addr,2'b00}).
  - dm_wd and dm_pc come from the head entry when !empty, else 0.
  - On a drain, at posedge the head entry's valid bit clears and head increments.
  - Latency: a store accepted at edge N is first drainable in the cycle after edge N. With no loads it is written into dm at edge N+1+k, where k is the number of older entries ahead of it.
- Count update:
  - push only: +1.
  - drain only: -1.
  - both: unchanged.
  - Push and drain in the same cycle while full: the push is still rejected, because st_ready is based on registered count.
- Load forwarding (combinational):
  - Compare ld_addr[31:2] against all valid entries.
  - ld_hit = ld_req && any match.
  - ld_data = data of the youngest matching entry, i.e. the match nearest tail going backwards; otherwise ld_data = dm_d.
  - A store pushed in the same cycle as a load is not visible to that load.
  - ld_data = dm_d when ld_req = 0.
- Wrap-around: pointers wrap from DEPTH-1 to 0; the youngest-match search must respect the wrapped order.
- Word-only: there is no byte or halfword masking; partial stores are outside this block.

Optional Feature:
- Macro: DM_SB_COALESCE_EN.
- Defined:
  - A push whose st_addr[31:2] equals the youngest valid entry (tail-1), and that entry is not the head being drained this cycle, overwrites that entry's wd and pc in place.
  - tail and count are unchanged.
  - Coalescing is allowed even when full: st_ready = !full || coalesce_hit.
- Undefined:
  - Every accepted store allocates a new entry.
  - st_ready = !full.

Test Plan:
- Reset, then store 0x00000004 <- 0x11111111 with no loads: dm_wr=1 on the next cycle with dm_a=0x00000004 and dm_wd=0x11111111, then empty=1.
- Push 4 stores (0x0, 0x4, 0x8, 0xC with data 1, 2, 3, 4) back-to-back while ld_req=1 throughout: st_ready=0 after the 4th; a 5th store is ignored; after ld_req drops, dm sees 4 writes in order on 4 consecutive cycles.
- Pending stores 0x10 <- 0xA and 0x10 <- 0xB, then a load from 0x12 with ld_req=1: ld_hit=1, ld_data=0xB; a load from 0x20 gives ld_hit=0 and ld_data=dm_d.
- Wrap: 6 stores interleaved with drains so the pointers pass index 3 -> 0; the youngest-match load returns the latest data and the drain order is preserved.
- Assert Reset with 3 entries pending: next cycle empty=1, dm_wr=0, and no further writes appear.
- With DM_SB_COALESCE_EN, two stores to 0x8 (0x5 then 0x6) while ld_req=1: count=1, and after release a single dm write 0x8 <- 0x6 occurs. Without the macro, count=2 and two writes occur.

Source files
------------

// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: datapath, store buffer and data memory signals.
// The slave modport is the store buffer itself; the master modport is the
// surrounding datapath plus data memory that drive its inputs.
interface dm_store_buffer_if;
  // datapath store side
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [31:0] st_pc;
  logic        st_ready;
  // datapath load side
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_hit;
  // data memory port
  logic        dm_wr;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_d;
  // status
  logic        empty;

  modport slave (
    input  st_req, st_addr, st_wd, st_pc, ld_req, ld_addr, dm_d,
    output st_ready, ld_data, ld_hit, dm_wr, dm_a, dm_wd, dm_pc, empty
  );

  modport master (
    output st_req, st_addr, st_wd, st_pc, ld_req, ld_addr, dm_d,
    input  st_ready, ld_data, ld_hit, dm_wr, dm_a, dm_wd, dm_pc, empty
  );
endinterface

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: FIFO of pending word stores in front of the data memory.
// Stores drain one per cycle whenever no load needs the dm address port;
// loads forward from the youngest matching pending store.
// Optional macro DM_SB_COALESCE_EN: a store to the same word as the youngest
// pending entry overwrites that entry instead of allocating a new one.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input logic              CLK,
  input logic              Reset,
  dm_store_buffer_if.slave bus
);

  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  // Entry storage: registers, since every entry is compared each cycle
  logic        valid_reg [DEPTH];
  logic [29:0] addr_reg  [DEPTH];
  logic [31:0] wd_reg    [DEPTH];
  logic [31:0] pc_reg    [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;

  logic             full;
  logic             is_empty;
  logic             drain;
  logic             push;
  logic             push_alloc;
  logic             push_coal;
  logic             coalesce_hit;
  logic [PW-1:0]    young_idx;
  logic [DEPTH-1:0] match;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [3:0]       unused_addr_lsb;

  // Byte offsets are irrelevant for word-only accesses.
  assign unused_addr_lsb = {bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign full      = (count_reg == CNT_FULL);
  assign is_empty  = (count_reg == '0);
  // Loads own the dm port; stores only drain in load-free cycles.
  assign drain     = !is_empty && !bus.ld_req;
  assign young_idx = tail_reg - PTR_ONE;

`ifdef DM_SB_COALESCE_EN
  // Never merge into the head while it is leaving this very cycle.
  assign coalesce_hit = !is_empty && valid_reg[young_idx] &&
                        (addr_reg[young_idx] == bus.st_addr[31:2]) &&
                        !(drain && (young_idx == head_reg));
`else
  assign coalesce_hit = 1'b0;
`endif

  assign bus.st_ready = !full || coalesce_hit;
  assign push         = bus.st_req && bus.st_ready;
  assign push_coal    = push && coalesce_hit;
  assign push_alloc   = push && !coalesce_hit;

  // Per-entry word match against the load address
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (addr_reg[gi] == bus.ld_addr[31:2]);
  end

  // Walk entries oldest to youngest from head so the last hit is the youngest,
  // which keeps the search correct when the valid range wraps past DEPTH-1.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + k[PW-1:0];
      if (match[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = wd_reg[idx];
      end
    end
  end

  assign bus.ld_hit  = bus.ld_req && fwd_hit;
  assign bus.ld_data = bus.ld_hit ? fwd_data : bus.dm_d;

  assign bus.empty = is_empty;
  assign bus.dm_wr = drain;
  assign bus.dm_a  = bus.ld_req ? {bus.ld_addr[31:2], 2'b00} :
                     (is_empty ? 32'h0 : {addr_reg[head_reg], 2'b00});
  assign bus.dm_wd = is_empty ? 32'h0 : wd_reg[head_reg];
  assign bus.dm_pc = is_empty ? 32'h0 : pc_reg[head_reg];

  // Occupancy: push and drain in the same cycle cancel out
  always_comb begin
    count_next = count_reg;
    case ({push_alloc, drain})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; reset discards everything pending
  always_ff @(posedge CLK) begin
    if (Reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push_alloc) tail_reg <= tail_reg + PTR_ONE;
      if (drain)      head_reg <= head_reg + PTR_ONE;
    end
  end

  // Entry writes: allocate at tail, merge into youngest, retire head
  always_ff @(posedge CLK) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (Reset) begin
        valid_reg[e] <= 1'b0;
      end else begin
        if (drain && (head_reg == e[PW-1:0])) valid_reg[e] <= 1'b0;
        if (push_alloc && (tail_reg == e[PW-1:0])) begin
          valid_reg[e] <= 1'b1;
          addr_reg[e]  <= bus.st_addr[31:2];
          wd_reg[e]    <= bus.st_wd;
          pc_reg[e]    <= bus.st_pc;
        end
        if (push_coal && (young_idx == e[PW-1:0])) begin
          wd_reg[e] <= bus.st_wd;
          pc_reg[e] <= bus.st_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed checks of store push, drain order, load
// forwarding, wrap-around, reset discard and (optionally) coalescing.
module tb_dm_store_buffer;
  localparam logic [31:0] DM_D = 32'hCAFE_BABE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dm_store_buffer_if sb_if ();

  dm_store_buffer #(.DEPTH(4), .PW(2)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (sb_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic req, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc);
    sb_if.st_req  = req;
    sb_if.st_addr = a;
    sb_if.st_wd   = wd;
    sb_if.st_pc   = pc;
  endtask

  task automatic set_ld(input logic req, input logic [31:0] a);
    sb_if.ld_req  = req;
    sb_if.ld_addr = a;
  endtask

  // Checks the dm write presented in the current cycle
  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] wd);
    chk({tag, "_wr"}, {31'h0, sb_if.dm_wr}, 32'h1);
    chk({tag, "_a"}, sb_if.dm_a, a);
    chk({tag, "_wd"}, sb_if.dm_wd, wd);
    $display("dm write %s: a=%h wd=%h", tag, sb_if.dm_a, sb_if.dm_wd);
  endtask

  initial begin
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b0, 32'h0);
    sb_if.dm_d = DM_D;

    // ---- reset state ----
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_empty", {31'h0, sb_if.empty}, 32'h1);
    chk("rst_st_ready", {31'h0, sb_if.st_ready}, 32'h1);
    chk("rst_dm_wr", {31'h0, sb_if.dm_wr}, 32'h0);
    chk("rst_dm_a", sb_if.dm_a, 32'h0);
    chk("rst_dm_wd", sb_if.dm_wd, 32'h0);
    chk("rst_dm_pc", sb_if.dm_pc, 32'h0);
    chk("rst_ld_hit", {31'h0, sb_if.ld_hit}, 32'h0);
    chk("rst_ld_data", sb_if.ld_data, DM_D);

    // ---- single store drains the cycle after it is accepted ----
    set_st(1'b1, 32'h4, 32'h1111_1111, 32'h100);
    #1;
    chk("s1_pre_wr", {31'h0, sb_if.dm_wr}, 32'h0);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk_wr("s1", 32'h4, 32'h1111_1111);
    chk("s1_pc", sb_if.dm_pc, 32'h100);
    chk("s1_empty", {31'h0, sb_if.empty}, 32'h0);
    cyc();
    chk("s1_post_empty", {31'h0, sb_if.empty}, 32'h1);
    chk("s1_post_wr", {31'h0, sb_if.dm_wr}, 32'h0);

    // ---- fill to full under a continuous load, 5th store dropped ----
    set_ld(1'b1, 32'h40);
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'(4 * i), 32'(i + 1), 32'(32'h200 + 4 * i));
      #1;
      chk("fill_ready", {31'h0, sb_if.st_ready}, 32'h1);
      cyc();
    end
    set_st(1'b1, 32'h30, 32'h55, 32'h210);
    #1;
    chk("full_ready", {31'h0, sb_if.st_ready}, 32'h0);
    chk("full_dm_wr", {31'h0, sb_if.dm_wr}, 32'h0);
    chk("full_dm_a", sb_if.dm_a, 32'h40);
    chk("full_ld_hit", {31'h0, sb_if.ld_hit}, 32'h0);
    chk("full_ld_data", sb_if.ld_data, DM_D);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b0, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_wr("fill", 32'(4 * i), 32'(i + 1));
      cyc();
    end
    chk("fill_empty", {31'h0, sb_if.empty}, 32'h1);
    chk("fill_no_5th", {31'h0, sb_if.dm_wr}, 32'h0);

    // ---- forwarding: youngest of two stores to the same word ----
    set_ld(1'b1, 32'h80);
    set_st(1'b1, 32'h10, 32'hA, 32'h300);
    cyc();
    set_st(1'b1, 32'h10, 32'hB, 32'h304);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b1, 32'h12);
    #1;
    chk("fwd_hit", {31'h0, sb_if.ld_hit}, 32'h1);
    chk("fwd_data", sb_if.ld_data, 32'hB);
    set_ld(1'b1, 32'h20);
    #1;
    chk("fwd_miss_hit", {31'h0, sb_if.ld_hit}, 32'h0);
    chk("fwd_miss_data", sb_if.ld_data, DM_D);
    set_ld(1'b0, 32'h10);
    #1;
    chk("fwd_noreq_hit", {31'h0, sb_if.ld_hit}, 32'h0);
    chk("fwd_noreq_data", sb_if.ld_data, DM_D);
`ifdef DM_SB_COALESCE_EN
    chk_wr("fwd_drain", 32'h10, 32'hB);
    cyc();
`else
    chk_wr("fwd_drain0", 32'h10, 32'hA);
    cyc();
    chk_wr("fwd_drain1", 32'h10, 32'hB);
    cyc();
`endif
    chk("fwd_empty", {31'h0, sb_if.empty}, 32'h1);

    // ---- wrap-around: six stores interleaved with drains ----
    set_ld(1'b1, 32'h300);
    set_st(1'b1, 32'h100, 32'h1, 32'h400);
    cyc();
    set_st(1'b1, 32'h104, 32'h2, 32'h404);
    cyc();
    set_st(1'b1, 32'h100, 32'h3, 32'h408);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b1, 32'h100);
    #1;
    chk("wrap_fwd3", sb_if.ld_data, 32'h3);
    set_ld(1'b0, 32'h0);
    set_st(1'b1, 32'h108, 32'h4, 32'h40C);
    #1;
    chk_wr("wrap_d1", 32'h100, 32'h1);
    cyc();
    set_st(1'b1, 32'h10C, 32'h5, 32'h410);
    #1;
    chk_wr("wrap_d2", 32'h104, 32'h2);
    cyc();
    set_ld(1'b1, 32'h100);
    set_st(1'b1, 32'h100, 32'h6, 32'h414);
    #1;
    chk("wrap_same_cyc_hit", {31'h0, sb_if.ld_hit}, 32'h1);
    chk("wrap_same_cyc_data", sb_if.ld_data, 32'h3);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("wrap_fwd6", sb_if.ld_data, 32'h6);
    chk("wrap_full", {31'h0, sb_if.st_ready}, 32'h0);
    set_ld(1'b0, 32'h0);
    #1;
    chk_wr("wrap_d3", 32'h100, 32'h3);
    cyc();
    chk_wr("wrap_d4", 32'h108, 32'h4);
    cyc();
    chk_wr("wrap_d5", 32'h10C, 32'h5);
    cyc();
    chk_wr("wrap_d6", 32'h100, 32'h6);
    cyc();
    chk("wrap_empty", {31'h0, sb_if.empty}, 32'h1);

    // ---- coalescing: two stores to one word while loads block draining ----
    set_ld(1'b1, 32'h300);
    set_st(1'b1, 32'h8, 32'h5, 32'h500);
    cyc();
    set_st(1'b1, 32'h8, 32'h6, 32'h504);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b0, 32'h0);
    #1;
`ifdef DM_SB_COALESCE_EN
    chk_wr("coal_only", 32'h8, 32'h6);
    chk("coal_pc", sb_if.dm_pc, 32'h504);
    cyc();
`else
    chk_wr("coal_first", 32'h8, 32'h5);
    cyc();
    chk_wr("coal_second", 32'h8, 32'h6);
    cyc();
`endif
    chk("coal_empty", {31'h0, sb_if.empty}, 32'h1);
    chk("coal_no_extra", {31'h0, sb_if.dm_wr}, 32'h0);

    // ---- reset with three entries pending, arriving mid-drain ----
    set_ld(1'b1, 32'h300);
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'(32'h600 + 4 * i), 32'(32'h70 + i), 32'h600);
      cyc();
    end
    set_st(1'b0, 32'h0, 32'h0, 32'h0);
    set_ld(1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst2_middrain_wr", {31'h0, sb_if.dm_wr}, 32'h1);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst2_empty", {31'h0, sb_if.empty}, 32'h1);
    chk("rst2_dm_wr", {31'h0, sb_if.dm_wr}, 32'h0);
    chk("rst2_st_ready", {31'h0, sb_if.st_ready}, 32'h1);
    chk("rst2_dm_wd", sb_if.dm_wd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst2_no_write", {31'h0, sb_if.dm_wr}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
